// File: rtl/fp_mul_seq_ctrl_pkg.sv
// Shared constants for the sequential binary32 multiplier controller:
// default field widths, FSM state encodings and flag bit positions.
package fp_mul_seq_ctrl_pkg;

    localparam int EXP_WIDTH_DEF = 8;
    localparam int MAN_WIDTH_DEF = 23;
    localparam int BIAS_DEF      = 127;

    // Controller states, kept as plain 2-bit constants for legacy tooling.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ITER  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    // Bit positions inside out_flags = {overflow, underflow, invalid}.
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INV = 0;

endpackage

// File: rtl/fp_mul_rne_round.sv
// Round-to-nearest-even of the raw significand product. Picks the 23 kept
// fraction bits and guard/round/sticky according to where the leading one
// landed, then rounds. A carry out of the rounded fraction means the
// significand became 10.000..0, i.e. 1.000..0 with the exponent bumped.
module fp_mul_rne_round #(
    parameter int MAN_WIDTH = 23
) (
    input  logic [2*MAN_WIDTH+1:0] prod,
    output logic                   carry,
    output logic [MAN_WIDTH-1:0]   man,
    output logic                   exp_inc
);

    logic [MAN_WIDTH-1:0] frac;
    logic                 guard;
    logic                 round_bit;
    logic                 sticky;
    logic                 inc;

    // Normalise by one position when the product is >= 2.0, then apply RNE.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path can leave it unassigned and infer a latch.
        carry     = prod[2*MAN_WIDTH+1];
        frac      = '0;
        guard     = 1'b0;
        round_bit = 1'b0;
        sticky    = 1'b0;
        if (carry) begin
            frac      = prod[2*MAN_WIDTH:MAN_WIDTH+1];
            guard     = prod[MAN_WIDTH];
            round_bit = prod[MAN_WIDTH-1];
            sticky    = |prod[MAN_WIDTH-2:0];
        end else begin
            frac      = prod[2*MAN_WIDTH-1:MAN_WIDTH];
            guard     = prod[MAN_WIDTH-1];
            round_bit = prod[MAN_WIDTH-2];
            sticky    = |prod[MAN_WIDTH-3:0];
        end
        inc            = guard & (round_bit | sticky | frac[0]);
        {exp_inc, man} = {1'b0, frac} + {{MAN_WIDTH{1'b0}}, inc};
    end

endmodule

// File: rtl/fp_mul_seq_ctrl.sv
// Multi-cycle binary32 multiplier controller. Takes one operand pair over
// valid/ready, short-circuits special operands, otherwise runs one shift-add
// step per cycle on the significands, rounds, and presents the packed result
// until the consumer takes it. Exactly one operation is ever in flight.
module fp_mul_seq_ctrl
    import fp_mul_seq_ctrl_pkg::*;
#(
    parameter int EXP_WIDTH = EXP_WIDTH_DEF,
    parameter int MAN_WIDTH = MAN_WIDTH_DEF,
    parameter int BIAS      = BIAS_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]   in_a,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]   in_b,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_WIDTH+MAN_WIDTH:0]   out_result,
    output logic [2:0]                     out_flags,
    output logic                           busy
);

    localparam int W      = 1 + EXP_WIDTH + MAN_WIDTH;
    localparam int SIG_W  = MAN_WIDTH + 1;           // significand incl. hidden 1
    localparam int PROD_W = 2 * SIG_W + 1;           // shift-add register
    localparam int CNT_W  = $clog2(SIG_W + 1);
    localparam int EW     = EXP_WIDTH + 2;           // signed exponent arithmetic

    localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_WIDTH-1){1'b0}}};
    localparam logic signed [EW-1:0] EXP_TOP  = EW'((1 << EXP_WIDTH) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;

    // Operand fields.
    logic                 sa, sb;
    logic [EXP_WIDTH-1:0] ea, eb;
    logic [MAN_WIDTH-1:0] fa, fb;
    assign {sa, ea, fa} = in_a;
    assign {sb, eb, fb} = in_b;

    // Controller state and datapath registers.
    logic [1:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [PROD_W-1:0]    prod;
    logic [MAN_WIDTH-1:0] man_a;
    logic [EXP_WIDTH-1:0] exp_a, exp_b;
    logic                 sign;

    // Special-operand classification of the pair on the input port.
    logic           spec_hit;
    logic [W-1:0]   spec_result;
    logic [2:0]     spec_flags;

    // One shift-add step and the rounding results.
    logic [PROD_W-1:0]    prod_add, prod_next;
    logic                 rnd_carry, rnd_exp_inc;
    logic [MAN_WIDTH-1:0] rnd_man;
    logic signed [EW-1:0] exp_calc;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_OUT);
    assign busy      = (state != ST_IDLE);

    // Classify the incoming pair: NaN and inf*zero beat the other specials,
    // and a zero exponent (zero or flushed denormal) counts as zero.
    always_comb begin
        logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        a_zero      = (ea == '0);
        b_zero      = (eb == '0);
        a_inf       = (ea == EXP_ONES) && (fa == '0);
        b_inf       = (eb == EXP_ONES) && (fb == '0);
        a_nan       = (ea == EXP_ONES) && (fa != '0);
        b_nan       = (eb == EXP_ONES) && (fb != '0);
        spec_hit    = 1'b1;
        spec_result = '0;
        spec_flags  = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            spec_result          = QNAN;
            spec_flags[FLAG_INV] = 1'b1;
        end else if (a_inf || b_inf) begin
            spec_result = {sa ^ sb, EXP_ONES, {MAN_WIDTH{1'b0}}};
        end else if (a_zero || b_zero) begin
            spec_result = {sa ^ sb, {(W-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Shift-add step: add {01,man_a} into the upper part when the current
    // multiplier bit is set, then shift the whole register right by one.
    always_comb begin
        prod_add = prod;
        if (prod[0]) begin
            prod_add[PROD_W-1:SIG_W] = prod[PROD_W-1:SIG_W] + {2'b01, man_a};
        end
        prod_next = prod_add >> 1;
    end

    fp_mul_rne_round #(
        .MAN_WIDTH (MAN_WIDTH)
    ) u_round (
        .prod    (prod[2*SIG_W-1:0]),
        .carry   (rnd_carry),
        .man     (rnd_man),
        .exp_inc (rnd_exp_inc)
    );

    // Biased result exponent; two extra bits expose both overflow and the
    // negative underflow range.
    assign exp_calc = EW'(exp_a) + EW'(exp_b) - EW'(BIAS)
                    + EW'(rnd_carry) + EW'(rnd_exp_inc);

    // Controller FSM with its counter, operand latches and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            prod       <= '0;
            man_a      <= '0;
            exp_a      <= '0;
            exp_b      <= '0;
            sign       <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign  <= sa ^ sb;
                        exp_a <= ea;
                        exp_b <= eb;
                        man_a <= fa;
                        prod  <= {{(SIG_W+1){1'b0}}, 1'b1, fb};
                        cnt   <= CNT_W'(SIG_W);
                        if (spec_hit) begin
                            out_result <= spec_result;
                            out_flags  <= spec_flags;
                            state      <= ST_OUT;
                        end else begin
                            state <= ST_ITER;
                        end
                    end
                end
                ST_ITER: begin
                    prod <= prod_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    out_flags <= '0;
                    if (exp_calc >= EXP_TOP) begin
                        out_result           <= {sign, EXP_ONES, {MAN_WIDTH{1'b0}}};
                        out_flags[FLAG_OVF]  <= 1'b1;
                    end else if (exp_calc <= EXP_ZERO) begin
                        out_result           <= {sign, {(W-1){1'b0}}};
                        out_flags[FLAG_UNF]  <= 1'b1;
                    end else begin
                        out_result <= {sign, exp_calc[EXP_WIDTH-1:0], rnd_man};
                    end
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
